// File: rtl/lcd1602_pkg.sv
// Shared HD44780-style definitions: FSM states, command classes, bit positions, line bases.
// Address-counter helpers handle the two-line wrap and line*LINE_LEN+column mapping.
package lcd1602_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    CMD_NOP,
    CMD_CLEAR,
    CMD_HOME,
    CMD_ENTRY,
    CMD_DISPLAY,
    CMD_SHIFT,
    CMD_FUNC,
    CMD_CGRAM,
    CMD_DDRAM
  } cmd_t;

  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam int         IDX_W      = 7;
  localparam logic [7:0] SPACE_CHAR = 8'h20;

  localparam int BIT_S  = 0;
  localparam int BIT_ID = 1;
  localparam int BIT_B  = 0;
  localparam int BIT_C  = 1;
  localparam int BIT_D  = 2;
  localparam int BIT_RL = 2;
  localparam int BIT_SC = 3;
  localparam int BIT_F  = 2;
  localparam int BIT_N  = 3;
  localparam int BIT_DL = 4;

  // The command class is chosen by the highest set bit of the byte.
  function automatic cmd_t decode_cmd(input logic [7:0] b);
    if (b[7])      return CMD_DDRAM;
    else if (b[6]) return CMD_CGRAM;
    else if (b[5]) return CMD_FUNC;
    else if (b[4]) return CMD_SHIFT;
    else if (b[3]) return CMD_DISPLAY;
    else if (b[2]) return CMD_ENTRY;
    else if (b[1]) return CMD_HOME;
    else if (b[0]) return CMD_CLEAR;
    else           return CMD_NOP;
  endfunction

  function automatic logic ac_valid(input logic [6:0] ac, input int line_len);
    return (ac < 7'(line_len)) ||
           ((ac >= LINE2_BASE) && (ac < LINE2_BASE + 7'(line_len)));
  endfunction

  function automatic logic [IDX_W-1:0] ac_to_idx(input logic [6:0] ac, input int line_len);
    return ac[6] ? (7'(line_len) + {1'b0, ac[5:0]}) : {1'b0, ac[5:0]};
  endfunction

  function automatic logic [6:0] ac_inc(input logic [6:0] ac, input int line_len);
    if (ac == LINE1_BASE + 7'(line_len - 1))      return LINE2_BASE;
    else if (ac == LINE2_BASE + 7'(line_len - 1)) return LINE1_BASE;
    else                                          return ac + 7'd1;
  endfunction

  function automatic logic [6:0] ac_dec(input logic [6:0] ac, input int line_len);
    if (ac == LINE1_BASE)      return LINE2_BASE + 7'(line_len - 1);
    else if (ac == LINE2_BASE) return LINE1_BASE + 7'(line_len - 1);
    else                       return ac - 7'd1;
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// Display data RAM: one write port, one registered read port (1-cycle latency, read-before-write).
// Unmapped reads (i_rd_en low) return a space; memory contents survive reset, only the read register clears.
module lcd_ddram
  import lcd1602_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 80
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_we,
  input  logic [IDX_W-1:0]     i_waddr,
  input  logic [DATA_BITS-1:0] i_wdata,
  input  logic                 i_rd_en,
  input  logic [IDX_W-1:0]     i_raddr,
  output logic [DATA_BITS-1:0] o_rd_data
);

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [DATA_BITS-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_rd_data <= '0;
    else         r_rd_data <= i_rd_en ? r_mem[i_raddr] : DATA_BITS'(SPACE_CHAR);
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/lcd1602_receiver.sv
// LCD1602 bus receiver: synchronises the enable strobe, decodes commands/data into a two-line DDRAM.
// Commands take one cycle, clear takes 2*LINE_LEN more; strobes while busy are dropped and flagged.
module lcd1602_receiver
  import lcd1602_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LINE_LEN    = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rs,
  input  logic                 rw,
  input  logic                 enable,
  input  logic [DATA_BITS-1:0] data,
  input  logic [6:0]           rd_addr,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 busy,
  output logic [6:0]           cursor_addr,
  output logic                 display_on,
  output logic                 cursor_on,
  output logic                 blink_on,
  output logic                 two_line,
  output logic                 font_5x10,
  output logic                 bus_8bit,
  output logic                 err_overrun,
  output logic                 err_addr,
  output logic                 err_read
);

  logic [SYNC_STAGES-1:0] r_en_sync;
  logic                   r_en_prev;
  logic                   w_strobe;

  state_t                 r_state;
  logic                   r_busy;
  logic                   r_rs;
  logic [DATA_BITS-1:0]   r_data;
  logic [6:0]             r_ac;
  logic                   r_id;
  logic                   r_entry_s_unused;  // stored shift bit; display shifting is not modelled
  logic [IDX_W-1:0]       r_clr_idx;
  logic                   r_disp, r_cur, r_blink, r_two_line, r_font, r_dl;
  logic                   r_err_overrun, r_err_addr, r_err_read;

  logic [7:0]             w_cmd;
  cmd_t                   w_cmd_kind;
  logic                   w_we;
  logic [IDX_W-1:0]       w_waddr;
  logic [DATA_BITS-1:0]   w_wdata;
  logic                   w_rd_hit;
  logic [IDX_W-1:0]       w_rd_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en_sync <= '0;
      r_en_prev <= 1'b0;
    end else begin
      r_en_sync[0] <= enable;
      for (int i = 1; i < SYNC_STAGES; i++) r_en_sync[i] <= r_en_sync[i-1];
      r_en_prev <= r_en_sync[SYNC_STAGES-1];
    end
  end

  assign w_strobe   = r_en_prev & ~r_en_sync[SYNC_STAGES-1];
  assign w_cmd      = r_data[7:0];
  assign w_cmd_kind = decode_cmd(w_cmd);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_busy           <= 1'b0;
      r_rs             <= 1'b0;
      r_data           <= '0;
      r_ac             <= LINE1_BASE;
      r_id             <= 1'b1;
      r_entry_s_unused <= 1'b0;
      r_clr_idx        <= '0;
      r_disp           <= 1'b0;
      r_cur            <= 1'b0;
      r_blink          <= 1'b0;
      r_two_line       <= 1'b0;
      r_font           <= 1'b0;
      r_dl             <= 1'b0;
      r_err_overrun    <= 1'b0;
      r_err_addr       <= 1'b0;
      r_err_read       <= 1'b0;
    end else begin
      if (w_strobe) begin
        if (r_state != ST_IDLE) r_err_overrun <= 1'b1;
        else if (rw)            r_err_read    <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_strobe && !rw) begin
            r_rs    <= rs;
            r_data  <= data;
            r_state <= ST_EXEC;
            r_busy  <= 1'b1;
          end
        end
        ST_EXEC: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          if (r_rs) begin
            r_ac <= r_id ? ac_inc(r_ac, LINE_LEN) : ac_dec(r_ac, LINE_LEN);
          end else begin
            case (w_cmd_kind)
              CMD_CLEAR: begin
                r_state   <= ST_CLEAR;
                r_busy    <= 1'b1;
                r_clr_idx <= '0;
              end
              CMD_HOME: r_ac <= LINE1_BASE;
              CMD_ENTRY: begin
                r_id             <= w_cmd[BIT_ID];
                r_entry_s_unused <= w_cmd[BIT_S];
              end
              CMD_DISPLAY: begin
                r_disp  <= w_cmd[BIT_D];
                r_cur   <= w_cmd[BIT_C];
                r_blink <= w_cmd[BIT_B];
              end
              CMD_SHIFT: begin
                if (!w_cmd[BIT_SC])
                  r_ac <= w_cmd[BIT_RL] ? ac_inc(r_ac, LINE_LEN) : ac_dec(r_ac, LINE_LEN);
              end
              CMD_FUNC: begin
                r_dl       <= w_cmd[BIT_DL];
                r_two_line <= w_cmd[BIT_N];
                r_font     <= w_cmd[BIT_F];
              end
              CMD_DDRAM: begin
                if (ac_valid(w_cmd[6:0], LINE_LEN)) r_ac       <= w_cmd[6:0];
                else                                r_err_addr <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_CLEAR: begin
          if (r_clr_idx == IDX_W'(2*LINE_LEN - 1)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_ac    <= LINE1_BASE;
            r_id    <= 1'b1;
          end else begin
            r_clr_idx <= r_clr_idx + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_we    = 1'b0;
    w_waddr = ac_to_idx(r_ac, LINE_LEN);
    w_wdata = r_data;
    if (r_state == ST_EXEC && r_rs) begin
      w_we = 1'b1;
    end else if (r_state == ST_CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_clr_idx;
      w_wdata = DATA_BITS'(SPACE_CHAR);
    end
  end

  assign w_rd_hit = ac_valid(rd_addr, LINE_LEN);
  assign w_rd_idx = ac_to_idx(rd_addr, LINE_LEN);

  lcd_ddram #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (2*LINE_LEN)
  ) u_ddram (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_rd_en   (w_rd_hit),
    .i_raddr   (w_rd_idx),
    .o_rd_data (rd_data)
  );

  assign busy        = r_busy;
  assign cursor_addr = r_ac;
  assign display_on  = r_disp;
  assign cursor_on   = r_cur;
  assign blink_on    = r_blink;
  assign two_line    = r_two_line;
  assign font_5x10   = r_font;
  assign bus_8bit    = r_dl;
  assign err_overrun = r_err_overrun;
  assign err_addr    = r_err_addr;
  assign err_read    = r_err_read;

endmodule

// File: tb/tb_lcd1602_receiver.sv
// Directed bench for lcd1602_receiver: bus strobes with hand-computed expected flags, AC and DDRAM contents.
module tb_lcd1602_receiver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rs = 1'b0, rw = 1'b0, enable = 1'b0;
  logic [7:0] data = 8'h00;
  logic [6:0] rd_addr = 7'h00;
  logic [7:0] rd_data;
  logic       busy;
  logic [6:0] cursor_addr;
  logic       display_on, cursor_on, blink_on, two_line, font_5x10, bus_8bit;
  logic       err_overrun, err_addr, err_read;

  int n_pass = 0;
  int n_total = 0;

  lcd1602_receiver #(.DATA_BITS(8), .SYNC_STAGES(2), .LINE_LEN(40)) dut (
    .clk(clk), .reset(reset), .rs(rs), .rw(rw), .enable(enable), .data(data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .cursor_addr(cursor_addr),
    .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .two_line(two_line), .font_5x10(font_5x10), .bus_8bit(bus_8bit),
    .err_overrun(err_overrun), .err_addr(err_addr), .err_read(err_read)
  );

  always #5 clk = ~clk;

  // Drive one bus cycle; returns 1ns after the edge on which enable is dropped.
  task automatic send(input logic rs_i, input logic rw_i, input logic [7:0] d);
    rs = rs_i; rw = rw_i; data = d; enable = 1'b1;
    repeat (4) @(posedge clk);
    #1 enable = 1'b0;
  endtask

  task automatic wait_idle(output int busy_cycles);
    busy_cycles = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (busy) busy_cycles++;
      else if (i >= 3) return;
    end
    $display("FAIL wait_idle: busy still %b after 300 cycles, want 0", busy);
    n_total++;
  endtask

  task automatic read_cell(input logic [6:0] a, output logic [7:0] v);
    rd_addr = a;
    @(posedge clk); #1;
    v = rd_data;
  endtask

  task automatic cmd(input logic [7:0] d);
    int bc;
    send(1'b0, 1'b0, d);
    wait_idle(bc);
  endtask

  task automatic wr(input logic [7:0] d);
    int bc;
    send(1'b1, 1'b0, d);
    wait_idle(bc);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk); #1;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++; n_total++;
    if (cursor_addr !== 7'h00) $display("FAIL reset_ac: got %h want 00", cursor_addr); else n_pass++; n_total++;
    if ({display_on, cursor_on, blink_on, two_line, font_5x10, bus_8bit} !== 6'b0)
      $display("FAIL reset_flags: got %b want 000000", {display_on, cursor_on, blink_on, two_line, font_5x10, bus_8bit});
    else n_pass++;
    n_total++;
    if ({err_overrun, err_addr, err_read} !== 3'b0)
      $display("FAIL reset_errs: got %b want 000", {err_overrun, err_addr, err_read}); else n_pass++; n_total++;
    if (rd_data !== 8'h00) $display("FAIL reset_rd_data: got %h want 00", rd_data); else n_pass++; n_total++;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_init;
    int bc;
    int bad;
    logic [7:0] v;
    cmd(8'h38); cmd(8'h06); cmd(8'h0C);
    send(1'b0, 1'b0, 8'h01);
    wait_idle(bc);
    if ({two_line, bus_8bit, font_5x10} !== 3'b110)
      $display("FAIL init_func: got N,DL,F=%b want 110", {two_line, bus_8bit, font_5x10}); else n_pass++; n_total++;
    if ({display_on, cursor_on, blink_on} !== 3'b100)
      $display("FAIL init_disp: got D,C,B=%b want 100", {display_on, cursor_on, blink_on}); else n_pass++; n_total++;
    if (bc != 81) $display("FAIL clear_busy_cycles: got %0d want 81", bc); else n_pass++; n_total++;
    if (cursor_addr !== 7'h00) $display("FAIL clear_ac: got %h want 00", cursor_addr); else n_pass++; n_total++;
    bad = 0;
    for (int a = 0; a < 40; a++) begin
      read_cell(7'(a), v);        if (v !== 8'h20) bad++;
      read_cell(7'(a) + 7'h40, v); if (v !== 8'h20) bad++;
    end
    if (bad != 0) $display("FAIL clear_cells: got %0d non-space cells want 0", bad); else n_pass++; n_total++;
  endtask

  task automatic test_data;
    logic [7:0] v;
    wr(8'h48); wr(8'h69);
    read_cell(7'h00, v);
    if (v !== 8'h48) $display("FAIL data_cell00: got %h want 48", v); else n_pass++; n_total++;
    read_cell(7'h01, v);
    if (v !== 8'h69) $display("FAIL data_cell01: got %h want 69", v); else n_pass++; n_total++;
    if (cursor_addr !== 7'h02) $display("FAIL data_ac: got %h want 02", cursor_addr); else n_pass++; n_total++;
  endtask

  task automatic test_wrap;
    logic [7:0] v;
    cmd(8'hA7);
    if (cursor_addr !== 7'h27) $display("FAIL set_ac_27: got %h want 27", cursor_addr); else n_pass++; n_total++;
    wr(8'h41);
    if (cursor_addr !== 7'h40) $display("FAIL wrap_27_40: got %h want 40", cursor_addr); else n_pass++; n_total++;
    read_cell(7'h27, v);
    if (v !== 8'h41) $display("FAIL wrap_cell27: got %h want 41", v); else n_pass++; n_total++;
    cmd(8'hE7); wr(8'h42);
    if (cursor_addr !== 7'h00) $display("FAIL wrap_67_00: got %h want 00", cursor_addr); else n_pass++; n_total++;
    read_cell(7'h67, v);
    if (v !== 8'h42) $display("FAIL wrap_cell67: got %h want 42", v); else n_pass++; n_total++;
  endtask

  task automatic test_decrement;
    logic [7:0] v;
    cmd(8'h04); cmd(8'h80); wr(8'h55);
    if (cursor_addr !== 7'h67) $display("FAIL dec_00_67: got %h want 67", cursor_addr); else n_pass++; n_total++;
    read_cell(7'h00, v);
    if (v !== 8'h55) $display("FAIL dec_cell00: got %h want 55", v); else n_pass++; n_total++;
    cmd(8'hC0); wr(8'h56);
    if (cursor_addr !== 7'h27) $display("FAIL dec_40_27: got %h want 27", cursor_addr); else n_pass++; n_total++;
    read_cell(7'h40, v);
    if (v !== 8'h56) $display("FAIL dec_cell40: got %h want 56", v); else n_pass++; n_total++;
    cmd(8'h14);
    if (cursor_addr !== 7'h40) $display("FAIL shift_right: got %h want 40", cursor_addr); else n_pass++; n_total++;
    cmd(8'h10);
    if (cursor_addr !== 7'h27) $display("FAIL shift_left: got %h want 27", cursor_addr); else n_pass++; n_total++;
    cmd(8'h18);
    if (cursor_addr !== 7'h27) $display("FAIL shift_display: got %h want 27", cursor_addr); else n_pass++; n_total++;
    cmd(8'h02);
    if (cursor_addr !== 7'h00) $display("FAIL home: got %h want 00", cursor_addr); else n_pass++; n_total++;
    cmd(8'h06);
  endtask

  task automatic test_errors;
    int bc;
    logic [7:0] v;
    cmd(8'hB0);
    if (err_addr !== 1'b1) $display("FAIL err_addr: got %b want 1", err_addr); else n_pass++; n_total++;
    if (cursor_addr !== 7'h00) $display("FAIL bad_addr_ac: got %h want 00", cursor_addr); else n_pass++; n_total++;
    send(1'b0, 1'b1, 8'h80);
    wait_idle(bc);
    if (err_read !== 1'b1) $display("FAIL err_read: got %b want 1", err_read); else n_pass++; n_total++;
    if (bc != 0) $display("FAIL read_not_exec: got %0d busy cycles want 0", bc); else n_pass++; n_total++;
    if (err_overrun !== 1'b0) $display("FAIL overrun_pre: got %b want 0", err_overrun); else n_pass++; n_total++;
    read_cell(7'h30, v);
    if (v !== 8'h20) $display("FAIL unmapped_30: got %h want 20", v); else n_pass++; n_total++;
    read_cell(7'h7F, v);
    if (v !== 8'h20) $display("FAIL unmapped_7f: got %h want 20", v); else n_pass++; n_total++;
    send(1'b0, 1'b0, 8'h01);
    repeat (3) @(posedge clk);
    #1 send(1'b1, 1'b0, 8'h5A);
    wait_idle(bc);
    repeat (8) @(posedge clk); #1;
    if (err_overrun !== 1'b1) $display("FAIL err_overrun: got %b want 1", err_overrun); else n_pass++; n_total++;
    if (cursor_addr !== 7'h00) $display("FAIL overrun_ac: got %h want 00", cursor_addr); else n_pass++; n_total++;
    read_cell(7'h00, v);
    if (v !== 8'h20) $display("FAIL overrun_cell00: got %h want 20", v); else n_pass++; n_total++;
  endtask

  task automatic test_back_to_back;
    int bc;
    logic [7:0] v;
    cmd(8'h85);
    rd_addr = 7'h05;
    send(1'b1, 1'b0, 8'h77);
    repeat (4) @(posedge clk); #1;
    if (rd_data !== 8'h20) $display("FAIL rw_same_old: got %h want 20", rd_data); else n_pass++; n_total++;
    @(posedge clk); #1;
    if (rd_data !== 8'h77) $display("FAIL rw_same_new: got %h want 77", rd_data); else n_pass++; n_total++;
    wait_idle(bc);
    wr(8'h31); wr(8'h32);
    if (cursor_addr !== 7'h08) $display("FAIL b2b_ac: got %h want 08", cursor_addr); else n_pass++; n_total++;
    read_cell(7'h07, v);
    if (v !== 8'h32) $display("FAIL b2b_cell07: got %h want 32", v); else n_pass++; n_total++;
  endtask

  task automatic test_reset_mid_clear;
    logic [7:0] v;
    cmd(8'h90); wr(8'h61);
    if (cursor_addr !== 7'h11) $display("FAIL pre_clear_ac: got %h want 11", cursor_addr); else n_pass++; n_total++;
    send(1'b0, 1'b0, 8'h01);
    repeat (10) @(posedge clk); #1;
    if (busy !== 1'b1) $display("FAIL mid_clear_busy: got %b want 1", busy); else n_pass++; n_total++;
    reset = 1'b1;
    #1;
    if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy); else n_pass++; n_total++;
    if (cursor_addr !== 7'h00) $display("FAIL rst_mid_ac: got %h want 00", cursor_addr); else n_pass++; n_total++;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (100) @(posedge clk); #1;
    if (busy !== 1'b0) $display("FAIL post_rst_busy: got %b want 0", busy); else n_pass++; n_total++;
    read_cell(7'h10, v);
    if (v !== 8'h61) $display("FAIL clear_abandoned: got %h want 61", v); else n_pass++; n_total++;
  endtask

  initial begin
    test_reset;
    test_init;
    test_data;
    test_wrap;
    test_decrement;
    test_errors;
    test_back_to_back;
    test_reset_mid_clear;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
